if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  IF-stage producer feeding the IF/ID pipeline register.
//  - Generates sequential PCs and issues in-order requests to the instruction memory.
//  - Buffers returned instructions in a small FIFO; presents the head as pc/pc4/instr/instr_valid.
//  - Honours the same stall/flush (redirect) control the IF/ID register receives.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH  2              instruction buffer entries (power of 2, >=2); also caps outstanding requests
// PORTS
//  clk               in   1   clock, rising edge
//  rst_n             in   1   asynchronous active-low reset
//  stall_i           in   1   hold: IF/ID not accepting this cycle
//  redirect_i        in   1   flush + new fetch target (branch/jump/trap)
//  redirect_pc_i     in   32  target PC when redirect_i=1
//  imem_req_o        out  1   request valid
//  imem_addr_o       out  32  request word address (byte addr, [1:0]=00)
//  imem_ready_i      in   1   request accepted when imem_req_o & imem_ready_i
//  imem_rvalid_i     in   1   response valid (in order, >=1 cycle after accept)
//  imem_rdata_i      in   32  response instruction
//  pc_if_o           out  32  PC of presented instruction
//  pc4_if_o          out  32  pc_if_o + 4
//  instr_if_o        out  32  presented instruction; 32'h0000_0013 (NOP) when not valid
//  instr_valid_if_o  out  1   presented instruction valid
//  misalign_o        out  1   misaligned-redirect flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0.
//   Outputs: imem_req_o=0, pc_if_o=0, pc4_if_o=4, instr_if_o=NOP, instr_valid_if_o=0, misalign_o=0.
//   imem_req_o may assert from the first cycle after reset release.
//  Issue: imem_req_o = !redirect_i & (outstanding + fifo_count < FIFO_DEPTH); imem_addr_o = fetch_pc.
//   On accept: fetch_pc += 4; outstanding++.
//  Response: each imem_rvalid_i decrements outstanding.
//   discard>0: data dropped, discard--. Else push {pc,instr} (pc tracked by response-PC reg += 4).
//   Push never overflows (credit rule guarantees it).
//  Output: head of FIFO, combinational from FIFO storage.
//   instr_valid_if_o = !empty & !redirect_i. Pop when !empty & !stall_i & !redirect_i.
//  Simultaneous push and pop on a full FIFO is legal; count unchanged.
//  Redirect (highest priority, beats stall_i): in that cycle, no request, no pop, instr_valid_if_o=0.
//   Next edge: FIFO cleared; fetch_pc and response-PC <= {redirect_pc_i[31:2],2'b00}.
//   discard <= outstanding minus any response consumed this cycle.
//   Response in the redirect cycle always belongs to the old stream and is dropped.
//  Back-to-back redirects: the last one wins; discard accumulates correctly.
//  stall_i with empty FIFO: no effect on issue; buffer fills up to FIFO_DEPTH.
//  fetch_pc wraps 32'hFFFF_FFFC -> 0 silently.
//  Latency: accept at cycle N, rvalid at N+k -> instr_valid_if_o at N+k+1; IF/ID captures at next edge.
// CONFIGURATION
//  IF_MISALIGN_CHK_EN defined:
//   redirect with redirect_pc_i[1:0]!=0 sets misalign_o=1 (registered), stores the target as-is.
//   Issue is suppressed while misalign_o=1; the next aligned redirect clears the flag and resumes.
//  IF_MISALIGN_CHK_EN undefined: misalign_o tied 0; low two bits forced to 00.
// TESTING
//  1 reset release, memory ready=1, latency 1 -> addrs 0,4,8...; valid stream pc 0,4,8 with pc4 = pc+4.
//  2 stall_i=1 for 5 cycles -> outputs frozen; at most FIFO_DEPTH requests outstanding+buffered; no loss or duplication.
//  3 redirect to 0x100 with 2 responses in flight -> both dropped; next valid pc=0x100, then 0x104.
//  4 redirect and stall_i same cycle -> redirect wins; instr_valid_if_o=0 that cycle; next fetch addr 0x100.
//  5 imem_ready_i toggling randomly with latency 1..3 -> in-order, gap-free pc sequence vs. reference model.
//  6 (IF_MISALIGN_CHK_EN) redirect 0x102 -> misalign_o=1, no requests; redirect 0x200 -> flag clears, fetch 0x200.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//
// Purpose:
//   Instruction-fetch producer for the IF/ID pipeline register. It walks a
//   sequential PC, issues in-order word requests to the instruction memory,
//   buffers the returned instructions in a small FIFO and presents the FIFO
//   head to IF/ID. A redirect (branch/jump/trap) flushes the buffer, retargets
//   the fetch PC and silently drops every response still in flight for the
//   old stream.
//
// Parameters:
//   RESET_PC    first PC fetched after reset
//   FIFO_DEPTH  buffer entries (power of 2, >= 2); also the cap on
//               outstanding requests plus buffered instructions
//
// Optional feature (compile-time macro IF_MISALIGN_CHK_EN):
//   defined   : a redirect whose target has [1:0] != 0 raises misalign_o,
//               keeps the target unmodified and blocks issue until the next
//               aligned redirect.
//   undefined : misalign_o is tied low and targets are forced word-aligned.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall_i           IF/ID is not accepting this cycle
//   redirect_i        flush + new fetch target redirect_pc_i
//   imem_req_o        request valid, address imem_addr_o
//   imem_ready_i      memory accepts the request this cycle
//   imem_rvalid_i     in-order response valid, data imem_rdata_i
//   pc_if_o/pc4_if_o  PC of the presented instruction and PC + 4
//   instr_if_o        presented instruction (NOP when not valid)
//   instr_valid_if_o  presented instruction valid
//   misalign_o        misaligned-redirect flag
// ----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_if_o,
   output logic [31:0] pc4_if_o,
   output logic [31:0] instr_if_o,
   output logic        instr_valid_if_o,
   output logic        misalign_o
);

   localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int            CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [31:0]   NOP     = 32'h0000_0013;

   // control state
   logic          r_active;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;

   // instruction buffer
   logic [31:0]   r_buf_pc    [FIFO_DEPTH];
   logic [31:0]   r_buf_instr [FIFO_DEPTH];

   logic          w_empty;
   logic [CW:0]   w_credits_used;
   logic          w_issue_ok;
   logic          w_hold;
   logic          w_req;
   logic          w_accept;
   logic          w_retire;
   logic          w_push;
   logic          w_pop;
   logic          w_valid;
   logic [31:0]   w_target;

`ifdef IF_MISALIGN_CHK_EN
   logic          r_misalign;

   // Misaligned targets are kept as-is so a trap handler can see them.
   assign w_target   = redirect_pc_i;
   assign w_hold     = r_misalign;
   assign misalign_o = r_misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else if (redirect_i) begin
         r_misalign <= (redirect_pc_i[1:0] != 2'b00);
      end
   end
`else
   assign w_target   = redirect_pc_i & 32'hFFFF_FFFC;
   assign w_hold     = 1'b0;
   assign misalign_o = 1'b0;
`endif

   assign w_empty        = (r_count == '0);

   // Credit rule: every request in flight already owns a buffer slot, so a
   // returning response can always be pushed without an overflow check.
   assign w_credits_used = {1'b0, r_outstanding} + {1'b0, r_count};
   assign w_issue_ok     = (w_credits_used < {1'b0, DEPTH_C});

   // r_active keeps the request line low while in reset and releases it on
   // the first edge after rst_n deasserts.
   assign w_req    = r_active & ~redirect_i & ~w_hold & w_issue_ok;
   assign w_accept = w_req & imem_ready_i;

   // A response with nothing outstanding is a protocol error; ignore it so
   // the counter cannot underflow.
   assign w_retire = imem_rvalid_i & (r_outstanding != '0);

   // Responses in the redirect cycle belong to the old stream by definition.
   assign w_push   = w_retire & ~redirect_i & (r_discard == '0);
   assign w_pop    = ~w_empty & ~stall_i & ~redirect_i;
   assign w_valid  = ~w_empty & ~redirect_i;

   assign imem_req_o       = w_req;
   assign imem_addr_o      = r_fetch_pc;
   assign pc_if_o          = r_buf_pc[r_rd_ptr];
   assign pc4_if_o         = r_buf_pc[r_rd_ptr] + 32'd4;
   assign instr_if_o       = w_valid ? r_buf_instr[r_rd_ptr] : NOP;
   assign instr_valid_if_o = w_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active      <= 1'b0;
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_count       <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
      end else begin
         r_active      <= 1'b1;
         r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_retire);
         if (redirect_i) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
            // Everything still in flight after this edge is old-stream data;
            // this also folds in any discard count left by an earlier redirect.
            r_discard  <= r_outstanding - CW'(w_retire);
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
         end else begin
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_retire && (r_discard != '0)) begin
               r_discard <= r_discard - CW'(1);
            end
            if (w_push) begin
               r_resp_pc <= r_resp_pc + 32'd4;
               r_wr_ptr  <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   // PC storage is reset so pc_if_o/pc4_if_o read 0/4 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_buf_pc[i] <= '0;
         end
      end else if (w_push) begin
         r_buf_pc[r_wr_ptr] <= r_resp_pc;
      end
   end

   // Instruction storage needs no reset: it is masked to NOP when not valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf_instr[r_wr_ptr] <= imem_rdata_i;
      end
   end

endmodule
